// File: rtl/player_motion_ctrl.sv
// rtl/player_motion_ctrl.sv - player sprite position and life/death controller
// Moves a rectangular sprite on one-hot buttons with wrap or clamp edges, and tracks lives.
module player_motion_ctrl #(
    parameter int H_RES         = 640,
    parameter int V_RES         = 480,
    parameter int POS_W         = 12,
    parameter int STEP          = 12,
    parameter int WRAP          = 1,
    parameter int LIVES         = 3,
    parameter int RESPAWN_TICKS = 16
) (
    input  logic             btnClk,
    input  logic             rst,
    input  logic             player_disable,
    input  logic [3:0]       move_en,
    input  logic [3:0]       btns,
    input  logic [POS_W-1:0] h_start,
    input  logic [POS_W-1:0] v_start,
    input  logic [POS_W-1:0] obj_w,
    input  logic [POS_W-1:0] obj_h,
    output logic [POS_W-1:0] h_pos,
    output logic [POS_W-1:0] v_pos,
    output logic             dead_pulse,
    output logic [3:0]       lives_left,
    output logic             game_over,
    output logic             alive
);

    typedef enum logic [2:0] {SPAWN, ALIVE, DYING, RESPAWN, OVER} state_t;

    localparam int CW = $clog2(RESPAWN_TICKS + 1);
    localparam logic [POS_W:0] STEP_X  = (POS_W+1)'(STEP);
    localparam logic [POS_W:0] H_RES_X = (POS_W+1)'(H_RES);
    localparam logic [POS_W:0] V_RES_X = (POS_W+1)'(V_RES);
    localparam logic [CW-1:0]  CNT_END = CW'(RESPAWN_TICKS - 1);

    state_t         state;
    logic [CW-1:0]  respawnCnt;
    logic [POS_W:0] hExt, vExt, hMax, vMax, hInc, vInc, hNew, vNew;

    // One extra bit of headroom so pos+STEP never wraps before the limit compare.
    always_comb begin
        hExt = {1'b0, h_pos};
        vExt = {1'b0, v_pos};
        hMax = H_RES_X - {1'b0, obj_w};
        vMax = V_RES_X - {1'b0, obj_h};
        hInc = hExt + STEP_X;
        vInc = vExt + STEP_X;
        hNew = hExt;
        vNew = vExt;
        case (btns)
            4'b1000: if (move_en[3])
                vNew = (vExt >= STEP_X) ? vExt - STEP_X : ((WRAP != 0) ? vMax : '0);
            4'b0100: if (move_en[2])
                vNew = (vInc <= vMax) ? vInc : ((WRAP != 0) ? '0 : vMax);
            4'b0010: if (move_en[1])
                hNew = (hInc <= hMax) ? hInc : ((WRAP != 0) ? '0 : hMax);
            4'b0001: if (move_en[0])
                hNew = (hExt >= STEP_X) ? hExt - STEP_X : ((WRAP != 0) ? hMax : '0);
            default: ;
        endcase
    end

    always_ff @(posedge btnClk or posedge rst) begin
        if (rst) begin
            state      <= SPAWN;
            h_pos      <= '0;
            v_pos      <= '0;
            dead_pulse <= 1'b0;
            lives_left <= 4'(LIVES);
            game_over  <= 1'b0;
            alive      <= 1'b0;
            respawnCnt <= '0;
        end else begin
            dead_pulse <= 1'b0;
            case (state)
                SPAWN: begin
                    h_pos <= h_start;
                    v_pos <= v_start;
                    state <= ALIVE;
                    alive <= 1'b1;
                end
                ALIVE: begin
                    if (!player_disable) begin
                        if (move_en == 4'b0000) begin
                            state      <= DYING;
                            alive      <= 1'b0;
                            dead_pulse <= 1'b1;
                            if (lives_left != 4'd0)
                                lives_left <= lives_left - 4'd1;
                        end else begin
                            h_pos <= hNew[POS_W-1:0];
                            v_pos <= vNew[POS_W-1:0];
                        end
                    end
                end
                DYING: begin
                    respawnCnt <= '0;
                    if (lives_left == 4'd0) begin
                        state     <= OVER;
                        game_over <= 1'b1;
                    end else begin
                        state <= RESPAWN;
                    end
                end
                RESPAWN: begin
                    if (respawnCnt == CNT_END)
                        state <= SPAWN;
                    else
                        respawnCnt <= respawnCnt + 1'b1;
                end
                OVER: game_over <= 1'b1;
                default: state <= SPAWN;
            endcase
        end
    end

endmodule
